exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Fetch/execute sequencer between the external program-load inputs, instruction memory and CPU datapath.
//  Captures bursts of 12-bit external instructions into imem. Then steps through the program one
//  instruction per debounced next_inst edge, or free-runs, issuing a one-cycle execute strobe per instruction.
//  Honours a datapath busy handshake; exposes pc, state and halt status for the 7-seg display path.
// PARAMETERS
//  INST_W     12  instruction width
//  IMEM_DEPTH 16  instruction memory words
//  PC_W       4   imem address width, = $clog2(IMEM_DEPTH)
// PORTS
//  clk         in  1        system clock, all state on rising edge
//  reset       in  1        asynchronous, active-low reset
//  load_inst   in  1        level: write inst_in into imem this cycle (when accepted)
//  inst_in     in  INST_W   external instruction word
//  next_inst   in  1        raw step request; rising edge = execute one instruction
//  run         in  1        level: auto-advance through program
//  imem_we     out 1        imem write enable (combinational)
//  imem_waddr  out PC_W     imem write address
//  imem_wdata  out INST_W   imem write data (= inst_in)
//  imem_raddr  out PC_W     imem read address (= pc[PC_W-1:0]); imem_rdata combinational
//  imem_rdata  in  INST_W   imem read data
//  dp_inst     out INST_W   registered instruction to datapath
//  dp_exec     out 1        one-cycle execute strobe
//  dp_busy     in  1        datapath still executing
//  pc          out PC_W+1   program counter, 0..IMEM_DEPTH
//  prog_len    out PC_W+1   words loaded, 0..IMEM_DEPTH
//  state       out 3        IDLE=0 LOAD=1 FETCH=2 EXEC=3 WAIT=4
//  halted      out 1        state==IDLE && prog_len!=0 && pc==prog_len
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; pc, prog_len, dp_inst, dp_exec, step_q = 0; outputs follow immediately.
//  Reset mid-operation aborts everything, with no partial strobe.
//  step_q <= next_inst; step_pulse = next_inst & ~step_q. Pulses outside IDLE are dropped, not queued.
//  IDLE:
//   - load_inst=1 has priority. Write inst_in to addr 0, prog_len<=1, pc<=0, -> LOAD.
//   - else if (step_pulse|run) && pc<prog_len -> FETCH.
//   - else stay.
//  LOAD:
//   - each load_inst=1 cycle writes at addr=prog_len, prog_len<=prog_len+1.
//   - if prog_len==IMEM_DEPTH (full): imem_we=0, word discarded, prog_len holds.
//   - load_inst=0 -> IDLE, with pc<=0.
//  FETCH: dp_inst<=imem_rdata at imem_raddr=pc; -> EXEC.
//  EXEC: dp_exec=1 (registered, exactly this cycle); pc<=pc+1; -> WAIT.
//  WAIT:
//   - dp_busy sampled from first WAIT cycle; stay while dp_busy=1.
//   - when dp_busy=0: run && pc<prog_len -> FETCH, else -> IDLE.
//  load_inst in FETCH/EXEC/WAIT: ignored (imem_we=0); takes effect once back in IDLE if still high.
//  Latency: step edge sampled in IDLE at cycle n -> FETCH n+1 -> dp_exec high n+2 -> WAIT n+3.
//  Single-cycle datapath (dp_busy=0): run issues dp_exec every 3 cycles.
//  pc never exceeds prog_len; no wrap. Reaching the end returns to IDLE with halted=1.
//  A new load clears halted (pc=0).
//  Every new load burst restarts at addr 0; earlier words beyond the new prog_len are stale and unreachable.
// TESTING
//  1 Run program with dp_busy=0, assert reset=0 while state=EXEC -> dp_exec, pc, prog_len = 0 and
//    state=IDLE before next clk edge.
//  2 load_inst=1 for 2 cycles with inst_in=12'h012, then 12'h214 -> imem writes (0,012),(1,214);
//    prog_len=2, pc=0, state back to IDLE.
//  3 After test 2, hold next_inst=1 for 5 cycles -> exactly one dp_exec, dp_inst=12'h012, pc=1.
//    Second edge -> dp_inst=12'h214, pc=2, halted=1. Third edge -> no dp_exec.
//  4 run=1, dp_busy high 3 cycles after each dp_exec -> dp_exec pulses spaced 6 cycles, pc increments by 1 each.
//  5 IMEM_DEPTH=16, load_inst high 17 cycles -> 16 writes at addr 0..15; 17th cycle imem_we=0; prog_len=16.
//  6 load_inst=1 during WAIT (dp_busy=1) -> no imem_we until state=IDLE, then write at addr 0, prog_len=1.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Fetch/execute sequencer sitting between the external program-load inputs,
//   the instruction memory and the CPU datapath. A burst of load_inst cycles
//   writes consecutive words into imem starting at address 0. The loaded
//   program then runs one instruction per rising edge of next_inst, or runs
//   freely while run is high. Each instruction gets a one-cycle dp_exec strobe.
//
// Ports
//   clk, reset          system clock; asynchronous active-low reset
//   load_inst, inst_in  program-load request (level) and the word to store
//   next_inst, run      single-step request (edge) / free-run enable (level)
//   imem_we/waddr/wdata imem write port (combinational)
//   imem_raddr/rdata    imem read port; rdata is combinational from raddr
//   dp_inst, dp_exec    registered instruction and one-cycle execute strobe
//   dp_busy             datapath still executing the last instruction
//   pc, prog_len        program counter and loaded length, both 0..IMEM_DEPTH
//   state, halted       FSM state (IDLE=0 LOAD=1 FETCH=2 EXEC=3 WAIT=4) and
//                       end-of-program flag
//
// Datapath handshake: dp_exec is high for exactly one cycle while dp_inst holds
// the instruction. From the cycle after that strobe the sequencer samples
// dp_busy every cycle and issues nothing further until it sees dp_busy low.
module exec_sequencer #(
  parameter int INST_W     = 12,
  parameter int IMEM_DEPTH = 16,
  parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_inst,
  input  logic [INST_W-1:0] inst_in,
  input  logic              next_inst,
  input  logic              run,
  output logic              imem_we,
  output logic [PC_W-1:0]   imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic [PC_W-1:0]   imem_raddr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] dp_inst,
  output logic              dp_exec,
  input  logic              dp_busy,
  output logic [PC_W:0]     pc,
  output logic [PC_W:0]     prog_len,
  output logic [2:0]        state,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [PC_W:0] FULL = (PC_W+1)'(IMEM_DEPTH);
  localparam logic [PC_W:0] ONE  = (PC_W+1)'(1);

  state_t              st, st_next;
  logic [PC_W:0]       pc_next, len_next;
  logic [INST_W-1:0]   inst_next;
  logic                exec_next;
  logic                step_q;
  logic                step_pulse;
  logic                more;

  // Only the rising edge of the raw step input counts; a held level does not
  // repeat, and edges that arrive outside IDLE are simply lost.
  assign step_pulse = next_inst & ~step_q;
  assign more       = (pc < prog_len);

  assign imem_wdata = inst_in;
  assign imem_raddr = pc[PC_W-1:0];
  assign state      = st;
  assign halted     = (st == IDLE) && (prog_len != '0) && (pc == prog_len);

  always_comb begin
    st_next    = st;
    pc_next    = pc;
    len_next   = prog_len;
    inst_next  = dp_inst;
    exec_next  = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = prog_len[PC_W-1:0];
    case (st)
      IDLE: begin
        // A load always starts a fresh program at address 0.
        if (load_inst) begin
          imem_we    = 1'b1;
          imem_waddr = '0;
          len_next   = ONE;
          pc_next    = '0;
          st_next    = LOAD;
        end else if ((step_pulse | run) && more) begin
          st_next = FETCH;
        end
      end
      LOAD: begin
        if (load_inst) begin
          // Words beyond the memory size are dropped; the length saturates.
          if (prog_len != FULL) begin
            imem_we  = 1'b1;
            len_next = prog_len + ONE;
          end
        end else begin
          pc_next = '0;
          st_next = IDLE;
        end
      end
      FETCH: begin
        inst_next = imem_rdata;
        exec_next = 1'b1;
        st_next   = EXEC;
      end
      EXEC: begin
        pc_next = pc + ONE;
        st_next = WAIT;
      end
      WAIT: begin
        if (!dp_busy) begin
          st_next = (run && more) ? FETCH : IDLE;
        end
      end
      default: st_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      pc       <= '0;
      prog_len <= '0;
      dp_inst  <= '0;
      dp_exec  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      st       <= st_next;
      pc       <= pc_next;
      prog_len <= len_next;
      dp_inst  <= inst_next;
      dp_exec  <= exec_next;
      step_q   <= next_inst;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer: directed scenarios followed by randomized
// load/step/run rounds, checked against a program-level reference model.
module tb_exec_sequencer;
  localparam int INST_W = 12;
  localparam int DEPTH  = 16;
  localparam int PC_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              load_inst = 1'b0;
  logic [INST_W-1:0] inst_in = '0;
  logic              next_inst = 1'b0;
  logic              run = 1'b0;
  logic              imem_we;
  logic [PC_W-1:0]   imem_waddr, imem_raddr;
  logic [INST_W-1:0] imem_wdata, imem_rdata, dp_inst;
  logic              dp_exec;
  logic              dp_busy = 1'b0;
  logic [PC_W:0]     pc, prog_len;
  logic [2:0]        state;
  logic              halted;

  exec_sequencer dut (
    .clk(clk), .reset(reset), .load_inst(load_inst), .inst_in(inst_in),
    .next_inst(next_inst), .run(run), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .dp_inst(dp_inst), .dp_exec(dp_exec), .dp_busy(dp_busy), .pc(pc),
    .prog_len(prog_len), .state(state), .halted(halted)
  );

  // ---------------- environment: imem, datapath, monitors ----------------
  logic [INST_W-1:0] env_mem [DEPTH];
  assign imem_rdata = env_mem[imem_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PC_W-1:0]   wr_addr[$];
  logic [INST_W-1:0] wr_data[$];
  logic [INST_W-1:0] got_inst[$];
  logic [PC_W:0]     got_pc[$];
  int                got_cyc[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      env_mem[imem_waddr] = imem_wdata;
    end
    if (dp_exec === 1'b1) begin
      got_inst.push_back(dp_inst);
      got_pc.push_back(pc);
      got_cyc.push_back(cyc);
    end
  end

  // Datapath model: busy for busy_len cycles after each execute strobe.
  int busy_len = 0;
  int busy_cnt = 0;
  always begin
    @(negedge clk);
    if (dp_exec === 1'b1) busy_cnt = busy_len;
    @(posedge clk);
    #1;
    if (busy_cnt > 0) begin
      dp_busy = 1'b1;
      busy_cnt--;
    end else begin
      dp_busy = 1'b0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [INST_W-1:0] ref_mem [DEPTH];
  int                ref_len = 0;
  int                ref_pc  = 0;
  logic [INST_W-1:0] burst_w [32];
  logic [INST_W-1:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete();
    got_inst.delete(); got_pc.delete(); got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max_cycles);
    int k = 0;
    do begin
      tick();
      k++;
    end while (state !== 3'd0 && k < max_cycles);
    chk("idle_reached", state, 0);
  endtask

  // Load burst_w[0..n-1]; only the first DEPTH words may be written.
  task automatic load_burst(input int n);
    int n_wr;
    clear_logs();
    n_wr = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < n; i++) begin
      inst_in   = burst_w[i];
      load_inst = 1'b1;
      #1;
      chk("load_we", imem_we, (i < DEPTH) ? 1 : 0);
      tick();
    end
    load_inst = 1'b0;
    tick();
    chk("load_state", state, 0);
    chk("load_len", prog_len, n_wr);
    chk("load_pc", pc, 0);
    chk("load_nwr", wr_addr.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_addr.size(); i++) begin
      chk("load_waddr", wr_addr[i], i);
      chk("load_wdata", wr_data[i], burst_w[i]);
    end
    for (int i = 0; i < n_wr; i++) ref_mem[i] = burst_w[i];
    ref_len = n_wr;
    ref_pc  = 0;
  endtask

  // One step request held for 'hold' cycles: at most one instruction.
  task automatic step(input int hold);
    int c0, n_exp;
    clear_logs();
    n_exp = (ref_pc < ref_len) ? 1 : 0;
    if (n_exp == 1) exp_q.push_back(ref_mem[ref_pc]);
    c0 = cyc;
    next_inst = 1'b1;
    repeat (hold) tick();
    next_inst = 1'b0;
    wait_idle(60);
    chk("step_count", got_inst.size(), n_exp);
    if (n_exp == 1 && got_inst.size() > 0) begin
      chk("step_inst", got_inst[0], exp_q.pop_front());
      chk("step_exec_pc", got_pc[0], ref_pc);
      chk("step_latency", got_cyc[0] - c0, 2);
    end
    ref_pc += n_exp;
    chk("step_pc", pc, ref_pc);
    chk("step_halted", halted, (ref_len != 0 && ref_pc == ref_len) ? 1 : 0);
  endtask

  // Free-run to the end of the program with a datapath busy for b cycles.
  task automatic run_prog(input int b);
    int c0, n_exp;
    clear_logs();
    busy_len = b;
    n_exp = ref_len - ref_pc;
    for (int i = ref_pc; i < ref_len; i++) exp_q.push_back(ref_mem[i]);
    c0 = cyc;
    run = 1'b1;
    repeat (n_exp * (3 + b) + 6) tick();
    run = 1'b0;
    wait_idle(20);
    chk("run_count", got_inst.size(), n_exp);
    for (int i = 0; i < n_exp && i < got_inst.size(); i++) begin
      chk("run_inst", got_inst[i], exp_q.pop_front());
      chk("run_exec_pc", got_pc[i], ref_pc + i);
      if (i == 0) chk("run_latency", got_cyc[0] - c0, 2);
      else        chk("run_spacing", got_cyc[i] - got_cyc[i-1], 3 + b);
    end
    ref_pc = ref_len;
    chk("run_pc", pc, ref_pc);
    chk("run_halted", halted, (ref_len != 0) ? 1 : 0);
  endtask

  task automatic wait_exec(input int nth, input string tag);
    int seen = 0;
    for (int k = 0; k < 100 && seen < nth; k++) begin
      @(negedge clk);
      if (dp_exec === 1'b1) seen++;
    end
    chk(tag, seen, nth);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_exec", dp_exec, 0);
    chk("rst_inst", dp_inst, 0);
    chk("rst_halted", halted, 0);
    chk("rst_we", imem_we, 0);
    reset = 1'b1;
    tick();

    // Two-word load, then single steps with a held step input
    burst_w[0] = 12'h012;
    burst_w[1] = 12'h214;
    load_burst(2);
    busy_len = 0;
    step(5);
    step(5);
    step(5);

    // Over-long load saturates at the memory size
    for (int i = 0; i < 17; i++) burst_w[i] = 12'($urandom);
    load_burst(17);

    // Free run with a 3-cycle busy datapath, then with a single-cycle one
    run_prog(3);
    load_burst(5);
    run_prog(0);

    // Load request during WAIT is held off until IDLE
    for (int i = 0; i < 3; i++) burst_w[i] = 12'($urandom);
    load_burst(3);
    clear_logs();
    busy_len = 6;
    run = 1'b1;
    wait_exec(1, "wait_exec_seen");
    @(posedge clk);
    #1;
    wr_addr.delete(); wr_data.delete();
    load_inst = 1'b1;
    inst_in   = 12'habc;
    run       = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      chk("wait_load_we", imem_we, 0);
      tick();
    end
    #1;
    chk("idle_load_we", imem_we, 1);
    chk("idle_load_addr", imem_waddr, 0);
    chk("idle_load_state", state, 0);
    tick();
    load_inst = 1'b0;
    tick();
    chk("late_load_len", prog_len, 1);
    chk("late_load_pc", pc, 0);
    chk("late_load_nwr", wr_addr.size(), 1);
    ref_mem[0] = 12'habc;
    ref_len = 1;
    ref_pc  = 0;
    busy_len = 0;
    step(1);

    // Reset asserted while in EXEC clears outputs immediately
    for (int i = 0; i < 4; i++) burst_w[i] = 12'($urandom);
    load_burst(4);
    busy_len = 0;
    run = 1'b1;
    wait_exec(2, "rst_exec_seen");
    reset = 1'b0;
    #1;
    chk("midrst_exec", dp_exec, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_len", prog_len, 0);
    chk("midrst_state", state, 0);
    run = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ref_len = 0;
    ref_pc  = 0;
    tick();
    step(2);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) burst_w[i] = 12'($urandom);
      load_burst(n);
      repeat ($urandom_range(1, 3)) begin
        busy_len = $urandom_range(0, 3);
        step($urandom_range(1, 4));
      end
      run_prog($urandom_range(0, 3));
      step($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
